// File: rtl/goertzel_bin_engine_pkg.sv
// Shared fixed-point constants and FSM state encoding for the Goertzel bin engine
// and its multiplier.
package goertzel_bin_engine_pkg;

    localparam int Q_FRAC   = 14;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/goertzel_bin_engine_mul.sv
// Registered 16x16 signed Q2.14 multiply with clock enable; truncates the product
// to bits [29:14] with no rounding or saturation.
module fix14_mul16
    import goertzel_bin_engine_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic signed [SAMPLE_W-1:0] a_i,
    input  logic signed [SAMPLE_W-1:0] b_i,
    output logic        [SAMPLE_W-1:0] p_o
);

    logic signed [2*SAMPLE_W-1:0] prod;
    logic        [SAMPLE_W-1:0]   p_q;
    logic                         unused_prod_bits;

    assign prod = a_i * b_i;
    // Integer bits above Q2.14 and the fractional tail are discarded by design.
    assign unused_prod_bits = ^{prod[2*SAMPLE_W-1:Q_FRAC+SAMPLE_W], prod[Q_FRAC-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= prod[Q_FRAC+SAMPLE_W-1:Q_FRAC];
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/goertzel_bin_engine.sv
// Single-bin Goertzel recursion over an external sample buffer; two enabled cycles
// per sample (MUL then ACC), final states latched into T1/T2 on FIN.
module goertzel_bin_engine
    import goertzel_bin_engine_pkg::*;
#(
    parameter int D_W         = 8,
    parameter int NUM_SAMPLES = 512,
    parameter int NS_BITS     = 9,
    parameter int OFFSET_BIN  = 1
) (
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] coeff,
    input  logic [D_W-1:0]      data_n,
    output logic [NS_BITS-1:0]  read_address,
    output logic                read_enable,
    output logic [SAMPLE_W-1:0] T1,
    output logic [SAMPLE_W-1:0] T2,
    output logic                ready,
    output logic                done
);

    localparam logic [NS_BITS-1:0] LAST_ADDR = NS_BITS'(NUM_SAMPLES - 1);

    state_e                state_q, state_d;
    logic [SAMPLE_W-1:0]   s1_q, s1_d, s2_q, s2_d;
    logic [SAMPLE_W-1:0]   t1_q, t1_d, t2_q, t2_d;
    logic [NS_BITS-1:0]    addr_q, addr_d;
    logic                  ren_q, ren_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic [D_W-1:0]        samp_raw;
    logic [SAMPLE_W-1:0]   x_val;
    logic [SAMPLE_W-1:0]   s0;
    logic [SAMPLE_W-1:0]   mult_out;

    generate
        if (OFFSET_BIN != 0) begin : g_offset
            assign samp_raw = {~data_n[D_W-1], data_n[D_W-2:0]};
        end else begin : g_twos
            assign samp_raw = data_n;
        end
    endgenerate

    assign x_val = SAMPLE_W'($signed(samp_raw));

    // Product of s1 and coeff is captured in MUL and consumed in the following ACC.
    fix14_mul16 u_mul (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .en_i  (enable && (state_q == MUL)),
        .a_i   (s1_q),
        .b_i   (coeff),
        .p_o   (mult_out)
    );

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        addr_d  = addr_q;
        ren_d   = ren_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        s0      = x_val + mult_out - s2_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    s1_d    = '0;
                    s2_d    = '0;
                    addr_d  = '0;
                    ren_d   = 1'b1;
                    ready_d = 1'b0;
                    state_d = MUL;
                end
            end
            MUL: begin
                state_d = ACC;
            end
            ACC: begin
                s2_d = s1_q;
                s1_d = s0;
                if (addr_q == LAST_ADDR) begin
                    state_d = FIN;
                end else begin
                    addr_d  = addr_q + NS_BITS'(1);
                    state_d = MUL;
                end
            end
            FIN: begin
                t1_d    = s1_q;
                t2_d    = s2_q;
                done_d  = 1'b1;
                ren_d   = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            addr_q  <= '0;
            ren_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            addr_q  <= addr_d;
            ren_q   <= ren_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign read_address = addr_q;
    assign read_enable  = ren_q;
    assign T1           = t1_q;
    assign T2           = t2_q;
    assign ready        = ready_q;
    assign done         = done_q;

endmodule

// File: tb/tb_goertzel_bin_engine.sv
// Bench for goertzel_bin_engine: three engine instances (N=512, 8, 6) each fed by a
// one-cycle-latency buffer model, plus a standalone multiplier instance.
module tb_goertzel_bin_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [2:0]  start_v;
    logic [15:0] coeff_v [3];
    logic [15:0] t1_v [3];
    logic [15:0] t2_v [3];
    logic [2:0]  rdy_v, done_v, ren_v;
    logic [8:0]  addr0;
    logic [2:0]  addr1, addr2;
    logic [7:0]  dn0, dn1, dn2;
    logic [7:0]  mem0 [512];
    logic [7:0]  mem1 [8];
    logic [7:0]  mem2 [8];

    logic        men;
    logic [15:0] ma, mb, mp;

    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    goertzel_bin_engine #(.D_W(8), .NUM_SAMPLES(512), .NS_BITS(9), .OFFSET_BIN(1)) u512 (
        .sys_clk(clk), .rst_n(rst_n), .enable(enable), .start(start_v[0]), .coeff(coeff_v[0]),
        .data_n(dn0), .read_address(addr0), .read_enable(ren_v[0]), .T1(t1_v[0]), .T2(t2_v[0]),
        .ready(rdy_v[0]), .done(done_v[0]));

    goertzel_bin_engine #(.D_W(8), .NUM_SAMPLES(8), .NS_BITS(3), .OFFSET_BIN(1)) u8 (
        .sys_clk(clk), .rst_n(rst_n), .enable(enable), .start(start_v[1]), .coeff(coeff_v[1]),
        .data_n(dn1), .read_address(addr1), .read_enable(ren_v[1]), .T1(t1_v[1]), .T2(t2_v[1]),
        .ready(rdy_v[1]), .done(done_v[1]));

    goertzel_bin_engine #(.D_W(8), .NUM_SAMPLES(6), .NS_BITS(3), .OFFSET_BIN(1)) u6 (
        .sys_clk(clk), .rst_n(rst_n), .enable(enable), .start(start_v[2]), .coeff(coeff_v[2]),
        .data_n(dn2), .read_address(addr2), .read_enable(ren_v[2]), .T1(t1_v[2]), .T2(t2_v[2]),
        .ready(rdy_v[2]), .done(done_v[2]));

    fix14_mul16 u_mul (.clk(clk), .rst_n(rst_n), .en_i(men), .a_i(ma), .b_i(mb), .p_o(mp));

    // Buffer model: data appears one enabled cycle after the address.
    always @(posedge clk) begin
        if (enable) begin
            dn0 <= mem0[addr0];
            dn1 <= mem1[addr1];
            dn2 <= mem2[addr2];
        end
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } mvec_t;

    typedef struct {
        int          sel;
        int          n_samp;
        logic [15:0] cf;
        logic [15:0] t1;
        logic [15:0] t2;
        bit          toggle;
    } run_t;

    mvec_t mvec [3];
    run_t  runs [4];

    task automatic check(input string name, input int act, input int exp);
        check_cnt++;
        if (act !== exp) begin
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic int cur_addr(input int sel);
        case (sel)
            0:       return int'(addr0);
            1:       return int'(addr1);
            default: return int'(addr2);
        endcase
    endfunction

    // Counts enabled edges after the start-accepting edge until done is seen.
    task automatic wait_done(input int sel, input int n_samp, input bit toggle,
                             output int n, output bit seen, output bit addr_ok);
        n       = 0;
        seen    = 1'b0;
        addr_ok = 1'b1;
        for (int it = 0; it < 8 * n_samp + 64; it++) begin
            if (toggle) begin
                enable       = 1'($urandom_range(0, 1));
                start_v[sel] = (n > 2 && n < 2 * n_samp - 2 && $urandom_range(0, 3) == 0);
            end
            @(posedge clk);
            if (enable) n++;
            @(negedge clk);
            if (n >= 1 && n <= 2 * n_samp - 1 && cur_addr(sel) != n / 2) addr_ok = 1'b0;
            if (done_v[sel]) begin
                seen = 1'b1;
                break;
            end
        end
        enable = 1'b1;
        if (toggle) start_v[sel] = 1'b0;
    endtask

    task automatic run_case(input int r);
        int n;
        bit seen, aok;
        int sel;
        sel          = runs[r].sel;
        coeff_v[sel] = runs[r].cf;
        enable       = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[sel] = 1'b0;
        check($sformatf("run%0d_ready_low", r), int'(rdy_v[sel]), 0);
        check($sformatf("run%0d_read_en", r), int'(ren_v[sel]), 1);
        wait_done(sel, runs[r].n_samp, runs[r].toggle, n, seen, aok);
        check($sformatf("run%0d_latency", r), seen ? n : -1, 2 * runs[r].n_samp + 1);
        check($sformatf("run%0d_T1", r), int'(t1_v[sel]), int'(runs[r].t1));
        check($sformatf("run%0d_T2", r), int'(t2_v[sel]), int'(runs[r].t2));
        check($sformatf("run%0d_ready_end", r), int'(rdy_v[sel]), 1);
        if (sel == 2) check($sformatf("run%0d_addr_seq", r), int'(aok), 1);
        @(posedge clk);
        @(negedge clk);
        check($sformatf("run%0d_done_one_cycle", r), int'(done_v[sel]), 0);
        $display("run %0d: N=%0d coeff=%h T1=%h T2=%h latency=%0d", r, runs[r].n_samp,
                 runs[r].cf, t1_v[sel], t2_v[sel], n);
    endtask

    initial begin
        int  n;
        bit  seen, aok;

        mvec[0] = '{16'h4000, 16'h2000, 16'h2000};
        mvec[1] = '{16'hC000, 16'h4000, 16'hC000};
        // Full-scale square truncated to bits [29:14] lands outside Q2.14 range.
        mvec[2] = '{16'h7FFF, 16'h7FFF, 16'hFFFC};

        runs[0] = '{0, 512, 16'h1413, 16'h0000, 16'h0000, 1'b0};
        runs[1] = '{1, 8,   16'h4000, 16'h0001, 16'h0001, 1'b0};
        runs[2] = '{2, 6,   16'h0000, 16'h0001, 16'h0001, 1'b0};
        runs[3] = '{1, 8,   16'h4000, 16'h0001, 16'h0001, 1'b1};

        for (int i = 0; i < 512; i++) mem0[i] = 8'h80;
        for (int i = 0; i < 8; i++) mem1[i] = (i == 0) ? 8'h81 : 8'h80;
        for (int i = 0; i < 8; i++) mem2[i] = 8'h81;

        rst_n   = 1'b0;
        enable  = 1'b0;
        start_v = '0;
        men     = 1'b0;
        ma      = '0;
        mb      = '0;
        for (int i = 0; i < 3; i++) coeff_v[i] = '0;
        repeat (2) @(negedge clk);

        check("reset_ready", int'(rdy_v), 3'b111);
        check("reset_done", int'(done_v), 0);
        check("reset_read_en", int'(ren_v), 0);
        check("reset_T1", int'(t1_v[1]), 0);
        check("reset_addr", int'(addr0), 0);
        check("reset_mul", int'(mp), 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ma  = mvec[i].a;
            mb  = mvec[i].b;
            men = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("mul%0d", i), int'(mp), int'(mvec[i].p));
            $display("mul %0d: %h * %h -> %h", i, mvec[i].a, mvec[i].b, mp);
        end
        men = 1'b0;
        ma  = 16'h1234;
        mb  = 16'h4000;
        @(posedge clk);
        @(negedge clk);
        check("mul_hold", int'(mp), 16'hFFFC);

        for (int r = 0; r < 4; r++) run_case(r);

        // Held start on the N=6 engine: re-triggers on the cycle after FIN.
        coeff_v[2] = 16'h0000;
        @(negedge clk);
        start_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(2, 6, 1'b0, n, seen, aok);
        check("held_latency1", seen ? n : -1, 13);
        check("held_ready_at_done", int'(rdy_v[2]), 1);
        @(posedge clk);
        @(negedge clk);
        check("held_retrigger", int'(rdy_v[2]), 0);
        start_v[2] = 1'b0;
        wait_done(2, 6, 1'b0, n, seen, aok);
        check("held_latency2", seen ? n : -1, 13);
        check("held_T1", int'(t1_v[2]), 1);
        $display("held start: second run T1=%h T2=%h", t1_v[2], t2_v[2]);

        // Abort the N=8 impulse run during the ACC of sample 3.
        coeff_v[1] = 16'h4000;
        @(negedge clk);
        start_v[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", int'(rdy_v[1]), 1);
        check("abort_done", int'(done_v[1]), 0);
        check("abort_T1", int'(t1_v[1]), 0);
        check("abort_T2", int'(t2_v[1]), 0);
        check("abort_read_en", int'(ren_v[1]), 0);
        $display("abort: ready=%b done=%b T1=%h T2=%h", rdy_v[1], done_v[1], t1_v[1], t2_v[1]);
        @(negedge clk);
        rst_n = 1'b1;
        run_case(1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
